// File: rtl/pir_pkg.sv
// Shared types and helpers for the PIR array monitor.
// Pure declarations; no latency, no backpressure.
// Consumers import pir_pkg::* for the state enum and arithmetic helpers.
package pir_pkg;

    typedef enum logic [1:0] {
        ST_OFF     = 2'd0,
        ST_IDLE    = 2'd1,
        ST_BUZZING = 2'd2,
        ST_CLEAR   = 2'd3
    } state_t;

    localparam int STATE_W = 2;

    // Index width that never collapses to zero bits for a single channel.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] max_val);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, max_val}) ? max_val : sum[31:0];
    endfunction

endpackage

// File: rtl/pir_array_monitor_if.sv
// Window-average output bus of the PIR monitor.
// avg_valid is a single-cycle pulse coincident with fresh avg_data.
// No backpressure: consumers must capture on the pulse.
interface pir_array_monitor_if #(
    parameter int NUM_CH   = 3,
    parameter int SAMPLE_W = 7
);
    logic [NUM_CH*SAMPLE_W-1:0] avg_data;
    logic                       avg_valid;

    modport master (output avg_data, output avg_valid);
    modport slave  (input  avg_data, input  avg_valid);
endinterface

// File: rtl/pir_channel_avg.sv
// Per-channel window accumulator, truncating average and threshold compare.
// avg/hit update one cycle after the window-close strobe.
// No backpressure: strobes come from the top-level counters.
module pir_channel_avg
    import pir_pkg::*;
#(
    parameter int SAMPLE_W = 7,
    parameter int AVG_LOG2 = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                sample_stb,
    input  logic                close_stb,
    input  logic [SAMPLE_W-1:0] sample,
    input  logic [SAMPLE_W-1:0] threshold,
    output logic [SAMPLE_W-1:0] avg,
    output logic                hit
);
    localparam int ACC_W = SAMPLE_W + AVG_LOG2;

    logic [ACC_W-1:0]    acc_q, acc_d, sum;
    logic [SAMPLE_W-1:0] avg_q, avg_d;
    logic                hit_q, hit_d;

    always_comb begin
        acc_d = acc_q;
        avg_d = avg_q;
        hit_d = hit_q;
        sum   = acc_q + ACC_W'(sample);
        if (clr) begin
            acc_d = '0;
            hit_d = 1'b0;
        end else if (close_stb) begin
            // Last sample of the window is folded in before the shift.
            acc_d = '0;
            avg_d = SAMPLE_W'(sum >> AVG_LOG2);
            hit_d = (avg_d >= threshold);
        end else if (sample_stb) begin
            acc_d = sum;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            avg_q <= '0;
            hit_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            avg_q <= avg_d;
            hit_q <= hit_d;
        end
    end

    assign avg = avg_q;
    assign hit = hit_q;

endmodule

// File: rtl/pir_array_monitor.sv
// N-channel PIR monitor: windowed averaging, threshold alarm FSM, trigger records.
// First avg_valid 4*SAMPLE_PERIOD cycles after IDLE entry; buzzer rises the cycle after.
// No backpressure: avg bus is a pulse, alarm outputs are levels.
module pir_array_monitor
    import pir_pkg::*;
#(
    parameter int NUM_CH        = 3,
    parameter int SAMPLE_W      = 7,
    parameter int SAMPLE_PERIOD = 4,
    parameter int AVG_LOG2      = 2,
    parameter int BUZZ_CYCLES   = 100,
    parameter int COUNT_W       = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            enable,
    input  logic                            stop_alarm,
    input  logic [SAMPLE_W-1:0]             threshold,
    input  logic [NUM_CH*SAMPLE_W-1:0]      sensor_data,
    pir_array_monitor_if.master             avg,
    output logic [NUM_CH-1:0]               led,
    output logic                            buzzer,
    output logic [SAMPLE_W-1:0]             peak_value,
    output logic [SAMPLE_W-1:0]             last_value,
    output logic [clog2_min1(NUM_CH)-1:0]   last_channel,
    output logic [COUNT_W-1:0]              trigger_count,
    output logic [STATE_W-1:0]              state_o
);
    localparam int CH_W     = clog2_min1(NUM_CH);
    localparam int SPC_W    = clog2_min1(SAMPLE_PERIOD);
    localparam int WIN_W    = (AVG_LOG2 < 1) ? 1 : AVG_LOG2;
    localparam int WIN_LAST = (1 << AVG_LOG2) - 1;
    localparam int BZ_W     = clog2_min1(BUZZ_CYCLES);

    state_t              state_q, state_d;
    logic [SPC_W-1:0]    sample_cnt_q, sample_cnt_d;
    logic [WIN_W-1:0]    win_cnt_q, win_cnt_d;
    logic [BZ_W-1:0]     buzz_cnt_q, buzz_cnt_d;
    logic                avg_valid_q, avg_valid_d;
    logic [NUM_CH-1:0]   led_q, led_d;
    logic                buzzer_q, buzzer_d;
    logic [SAMPLE_W-1:0] peak_q, peak_d;
    logic [SAMPLE_W-1:0] last_value_q, last_value_d;
    logic [CH_W-1:0]     last_channel_q, last_channel_d;
    logic [COUNT_W-1:0]  trig_q, trig_d;

    logic                sample_stb, close_stb, ch_clr;
    logic [NUM_CH-1:0]   hit;
    logic [SAMPLE_W-1:0] ch_avg [NUM_CH];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        pir_channel_avg #(
            .SAMPLE_W (SAMPLE_W),
            .AVG_LOG2 (AVG_LOG2)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .clr        (ch_clr),
            .sample_stb (sample_stb),
            .close_stb  (close_stb),
            .sample     (sensor_data[i*SAMPLE_W +: SAMPLE_W]),
            .threshold  (threshold),
            .avg        (ch_avg[i]),
            .hit        (hit[i])
        );
        assign avg.avg_data[i*SAMPLE_W +: SAMPLE_W] = ch_avg[i];
    end

    always_comb begin
        int pc;
        state_d        = state_q;
        sample_cnt_d   = sample_cnt_q;
        win_cnt_d      = win_cnt_q;
        buzz_cnt_d     = buzz_cnt_q;
        avg_valid_d    = 1'b0;
        led_d          = led_q;
        buzzer_d       = buzzer_q;
        peak_d         = peak_q;
        last_value_d   = last_value_q;
        last_channel_d = last_channel_q;
        trig_d         = trig_q;
        sample_stb     = 1'b0;
        close_stb      = 1'b0;
        ch_clr         = 1'b0;
        pc             = 0;

        unique case (state_q)
            ST_OFF: begin
                sample_cnt_d = '0;
                win_cnt_d    = '0;
                led_d        = '0;
                buzzer_d     = 1'b0;
                ch_clr       = 1'b1;
                if (enable) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (!enable) begin
                    state_d      = ST_OFF;
                    sample_cnt_d = '0;
                    win_cnt_d    = '0;
                    ch_clr       = 1'b1;
                end else if (avg_valid_q && (|hit)) begin
                    state_d    = ST_BUZZING;
                    buzzer_d   = 1'b1;
                    led_d      = hit;
                    buzz_cnt_d = '0;
                    // Ascending scan so the highest-index hit wins the last_* record.
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (hit[i]) begin
                            pc             = pc + 1;
                            last_value_d   = ch_avg[i];
                            last_channel_d = CH_W'(i);
                            if (ch_avg[i] > peak_d) peak_d = ch_avg[i];
                        end
                    end
                    trig_d = COUNT_W'(sat_add(32'(trig_q), 32'(pc), 32'({COUNT_W{1'b1}})));
                end else begin
                    if (sample_cnt_q == SPC_W'(SAMPLE_PERIOD - 1)) begin
                        sample_cnt_d = '0;
                        sample_stb   = 1'b1;
                        if (win_cnt_q == WIN_W'(WIN_LAST)) begin
                            close_stb   = 1'b1;
                            avg_valid_d = 1'b1;
                            win_cnt_d   = '0;
                        end else begin
                            win_cnt_d = win_cnt_q + WIN_W'(1);
                        end
                    end else begin
                        sample_cnt_d = sample_cnt_q + SPC_W'(1);
                    end
                end
            end
            ST_BUZZING: begin
                buzz_cnt_d = buzz_cnt_q + BZ_W'(1);
                if (stop_alarm || !enable || (buzz_cnt_q == BZ_W'(BUZZ_CYCLES - 1))) begin
                    state_d  = ST_CLEAR;
                    buzzer_d = 1'b0;
                    led_d    = '0;
                end
            end
            ST_CLEAR: begin
                sample_cnt_d = '0;
                win_cnt_d    = '0;
                buzz_cnt_d   = '0;
                ch_clr       = 1'b1;
                state_d      = enable ? ST_IDLE : ST_OFF;
            end
            default: state_d = ST_OFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_OFF;
            sample_cnt_q   <= '0;
            win_cnt_q      <= '0;
            buzz_cnt_q     <= '0;
            avg_valid_q    <= 1'b0;
            led_q          <= '0;
            buzzer_q       <= 1'b0;
            peak_q         <= '0;
            last_value_q   <= '0;
            last_channel_q <= '0;
            trig_q         <= '0;
        end else begin
            state_q        <= state_d;
            sample_cnt_q   <= sample_cnt_d;
            win_cnt_q      <= win_cnt_d;
            buzz_cnt_q     <= buzz_cnt_d;
            avg_valid_q    <= avg_valid_d;
            led_q          <= led_d;
            buzzer_q       <= buzzer_d;
            peak_q         <= peak_d;
            last_value_q   <= last_value_d;
            last_channel_q <= last_channel_d;
            trig_q         <= trig_d;
        end
    end

    assign avg.avg_valid  = avg_valid_q;
    assign led            = led_q;
    assign buzzer         = buzzer_q;
    assign peak_value     = peak_q;
    assign last_value     = last_value_q;
    assign last_channel   = last_channel_q;
    assign trigger_count  = trig_q;
    assign state_o        = state_q;

endmodule
